// File: rtl/mc_core_hs_if.sv
// Unified instruction/data memory bus for mc_core_hs.
// req/ack handshake: the core holds a request until the edge where ack=1.
interface mc_core_hs_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mc_core_hs.sv
// Multicycle MIPS-subset core with req/ack memory handshake.
// Optional overflow trap (TRAP state, trap port) under `MC_OVF_TRAP_EN.
module mc_core_hs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic         clk,
  input  logic         rst,
  mc_core_hs_if.master mem,
  output logic [31:0]  pc,
  output logic [31:0]  instruction,
  output logic [31:0]  ALUOut,
  output logic         overflow,
  output logic         retire,
  output logic         illegal
`ifdef MC_OVF_TRAP_EN
  ,
  output logic         trap
`endif
);

  localparam int IW = $clog2(NREGS);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC,
    ALUWB,
    ADDIEX,
    ADDIWB,
    BRANCH,
    JUMP,
    ILLEGAL
`ifdef MC_OVF_TRAP_EN
    ,
    TRAP
`endif
  } state_t;

  state_t state;
  state_t state_n;

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] mdr;
  logic [31:0] rf [NREGS];

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [IW-1:0] rs;
  logic [IW-1:0] rt;
  logic [IW-1:0] rd;
  logic [31:0]   simm;

  assign op    = instruction[31:26];
  assign funct = instruction[5:0];
  assign rs    = instruction[21 +: IW];
  assign rt    = instruction[16 +: IW];
  assign rd    = instruction[11 +: IW];
  assign simm  = {{16{instruction[15]}}, instruction[15:0]};

  logic is_r;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_addi;
  logic is_j;

  assign is_r    = (op == 6'h00) &&
                   (funct inside {6'h20, 6'h22, 6'h24,
                                  6'h25, 6'h2A});
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_addi = (op == 6'h08);
  assign is_j    = (op == 6'h02);

  logic [31:0] alu_b;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] alu_y;
  logic        add_ovf;
  logic        sub_ovf;
  logic        alu_ovf;

  assign alu_b   = (state == EXEC) ? b : simm;
  assign sum     = a + alu_b;
  assign diff    = a - alu_b;
  assign add_ovf = (a[31] == alu_b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != alu_b[31]) && (diff[31] != a[31]);

  always_comb begin
    alu_y   = sum;
    alu_ovf = add_ovf;
    if (state == EXEC) begin
      case (funct)
        6'h22: begin
          alu_y   = diff;
          alu_ovf = sub_ovf;
        end
        6'h24: begin
          alu_y   = a & b;
          alu_ovf = 1'b0;
        end
        6'h25: begin
          alu_y   = a | b;
          alu_ovf = 1'b0;
        end
        6'h2A: begin
          alu_y   = {31'b0, $signed(a) < $signed(b)};
          alu_ovf = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Only arithmetic execute states report overflow; address calc does not.
  assign overflow = alu_ovf && ((state == EXEC) || (state == ADDIEX));

  logic          req;
  logic          we;
  logic [31:0]   addr;
  logic          ret;
  logic          rf_we;
  logic [IW-1:0] rf_wa;
  logic [31:0]   rf_wd;
`ifdef MC_OVF_TRAP_EN
  logic          trap_c;
`endif

  always_comb begin
    state_n = state;
    req     = 1'b0;
    we      = 1'b0;
    addr    = pc;
    ret     = 1'b0;
    rf_we   = 1'b0;
    rf_wa   = rt;
    rf_wd   = ALUOut;
`ifdef MC_OVF_TRAP_EN
    trap_c  = 1'b0;
`endif
    case (state)
      FETCH: begin
        req = 1'b1;
        if (mem.mem_ack) state_n = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          is_lw || is_sw: state_n = MEMADR;
          is_r:           state_n = EXEC;
          is_addi:        state_n = ADDIEX;
          is_beq:         state_n = BRANCH;
          is_j:           state_n = JUMP;
          default:        state_n = ILLEGAL;
        endcase
      end
      MEMADR: state_n = is_lw ? MEMRD : MEMWR;
      MEMRD: begin
        req  = 1'b1;
        addr = ALUOut;
        if (mem.mem_ack) state_n = MEMWB;
      end
      MEMWB: begin
        rf_we   = 1'b1;
        rf_wd   = mdr;
        ret     = 1'b1;
        state_n = FETCH;
      end
      MEMWR: begin
        req  = 1'b1;
        we   = 1'b1;
        addr = ALUOut;
        if (mem.mem_ack) begin
          ret     = 1'b1;
          state_n = FETCH;
        end
      end
`ifdef MC_OVF_TRAP_EN
      EXEC:   state_n = overflow ? TRAP : ALUWB;
      ADDIEX: state_n = overflow ? TRAP : ADDIWB;
      TRAP: begin
        trap_c  = 1'b1;
        state_n = FETCH;
      end
`else
      EXEC:   state_n = ALUWB;
      ADDIEX: state_n = ADDIWB;
`endif
      ALUWB: begin
        rf_we   = 1'b1;
        rf_wa   = rd;
        ret     = 1'b1;
        state_n = FETCH;
      end
      ADDIWB: begin
        rf_we   = 1'b1;
        ret     = 1'b1;
        state_n = FETCH;
      end
      BRANCH, JUMP: begin
        ret     = 1'b1;
        state_n = FETCH;
      end
      ILLEGAL: state_n = ILLEGAL;
      default: state_n = FETCH;
    endcase
  end

  // Handshake and strobes are forced low while reset is asserted.
  assign mem.mem_req   = req & rst;
  assign mem.mem_we    = we & rst;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = b;
  assign retire        = ret & rst;
`ifdef MC_OVF_TRAP_EN
  assign trap          = trap_c & rst;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instruction <= '0;
      ALUOut      <= '0;
      a           <= '0;
      b           <= '0;
      mdr         <= '0;
      illegal     <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      state <= state_n;
      if (state_n == ILLEGAL) illegal <= 1'b1;
      if (rf_we && (rf_wa != '0)) rf[rf_wa] <= rf_wd;
      case (state)
        FETCH: begin
          if (mem.mem_ack) begin
            instruction <= mem.mem_rdata;
            pc          <= pc + 32'd4;
          end
        end
        DECODE: begin
          a      <= rf[rs];
          b      <= rf[rt];
          ALUOut <= pc + {simm[29:0], 2'b00};
        end
        MEMADR, EXEC, ADDIEX: ALUOut <= alu_y;
        MEMRD: begin
          if (mem.mem_ack) mdr <= mem.mem_rdata;
        end
        BRANCH: begin
          if (a == b) pc <= ALUOut;
        end
        JUMP: pc <= {pc[31:28], instruction[25:0], 2'b00};
`ifdef MC_OVF_TRAP_EN
        TRAP: pc <= 32'h0000_0080;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_core_hs.sv
// Self-checking bench for mc_core_hs: memory model with wait states,
// store scoreboard, retire/overflow/handshake monitors.
module tb_mc_core_hs;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mc_core_hs_if bus();

  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] alu_out;
  logic        overflow;
  logic        retire;
  logic        illegal;
`ifdef MC_OVF_TRAP_EN
  logic        trap;
`endif

  mc_core_hs dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (bus),
    .pc          (pc),
    .instruction (instruction),
    .ALUOut      (alu_out),
    .overflow    (overflow),
    .retire      (retire),
    .illegal     (illegal)
`ifdef MC_OVF_TRAP_EN
    ,
    .trap        (trap)
`endif
  );

  localparam logic [31:0] ILL = 32'hFC00_0000;

  logic [31:0] prog [256];
  logic [31:0] dmem [256];
  logic        dval [256];
  int          dly  = 0;
  logic        spur = 1'b0;
  int          wcnt = 0;

  logic [7:0] widx;
  assign widx = bus.mem_addr[9:2];
  assign bus.mem_ack = (bus.mem_req && (wcnt >= dly)) || spur;
  assign bus.mem_rdata = dval[widx] ? dmem[widx] : prog[widx];

  int          cyc      = 0;
  int          ret_cnt  = 0;
  int          ovf_cnt  = 0;
  int          trap_cnt = 0;
  int          stab_err = 0;
  int          req_rst  = 0;
  logic        in_txn   = 1'b0;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_we;
  logic [31:0] obs_addr [$];
  logic [31:0] obs_data [$];
  int          ret_cyc  [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (retire) begin
      ret_cnt <= ret_cnt + 1;
      ret_cyc.push_back(cyc);
    end
    if (overflow) ovf_cnt <= ovf_cnt + 1;
`ifdef MC_OVF_TRAP_EN
    if (trap) trap_cnt <= trap_cnt + 1;
`endif
    if (!rst) begin
      wcnt   <= 0;
      in_txn <= 1'b0;
      if (bus.mem_req) req_rst <= req_rst + 1;
      for (int i = 0; i < 256; i++) dval[i] <= 1'b0;
    end else if (bus.mem_req) begin
      if (in_txn && ((bus.mem_addr !== cap_addr) ||
                     (bus.mem_we !== cap_we) ||
                     (cap_we && (bus.mem_wdata !== cap_wdata))))
        stab_err <= stab_err + 1;
      if (!in_txn) begin
        cap_addr  <= bus.mem_addr;
        cap_we    <= bus.mem_we;
        cap_wdata <= bus.mem_wdata;
      end
      in_txn <= !bus.mem_ack;
      wcnt   <= bus.mem_ack ? 0 : wcnt + 1;
      if (bus.mem_ack && bus.mem_we) begin
        dmem[widx] <= bus.mem_wdata;
        dval[widx] <= 1'b1;
        obs_addr.push_back(bus.mem_addr);
        obs_data.push_back(bus.mem_wdata);
      end
    end else begin
      in_txn <= 1'b0;
      wcnt   <= 0;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  function automatic logic [31:0] ei(input logic [5:0] op,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic [4:0] rd,
                                     input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] ej(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic hold_reset();
    @(negedge clk);
    rst  = 1'b0;
    spur = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 256; i++) prog[i] = ILL;
  endtask

  task automatic wait_halt(input int bound, output bit tmo);
    tmo = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (illegal === 1'b1) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_ret(input int base, input int n,
                          input int bound, output bit tmo);
    tmo = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (ret_cnt - base >= n) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    hold_reset();
    spur = 1'b1;
    #1;
    checks += 7;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL rst_pc got %h want 0", pc);
    end
    if (instruction !== 32'h0) begin
      errors++; $display("FAIL rst_ir got %h want 0", instruction);
    end
    if (alu_out !== 32'h0) begin
      errors++; $display("FAIL rst_aluout got %h want 0", alu_out);
    end
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_req got %b want 0", bus.mem_req);
    end
    if (retire !== 1'b0) begin
      errors++; $display("FAIL rst_retire got %b want 0", retire);
    end
    if (illegal !== 1'b0) begin
      errors++; $display("FAIL rst_illegal got %b want 0", illegal);
    end
    if (req_rst !== 0) begin
      errors++; $display("FAIL rst_req_cycles got %0d want 0", req_rst);
    end
    spur = 1'b0;
    prog[0] = ei(6'h08, 0, 1, 16'h0005);
    dly = 4;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    spur = 1'b1;
    @(posedge clk);
    #1;
    spur = 1'b0;
    checks += 2;
    if (instruction !== 32'h0) begin
      errors++; $display("FAIL midrst_ir got %h want 0", instruction);
    end
    if (pc !== 32'h0) begin
      errors++; $display("FAIL midrst_pc got %h want 0", pc);
    end
  endtask

  task automatic test_addi();
    logic [63:0] e;
    int rb, oi;
    bit tmo;
    hold_reset();
    dly = 0;
    prog[0] = ei(6'h08, 0, 1, 16'h0005);
    prog[1] = ei(6'h2B, 0, 1, 16'h0200);
    exp_q.push_back({32'h200, 32'd5});
    rb = ret_cnt;
    oi = obs_addr.size();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL addi_first_req got req=%b addr=%h want 1/0",
               bus.mem_req, bus.mem_addr);
    end
    repeat (4) @(posedge clk);
    #1;
    checks += 2;
    if (ret_cnt - rb !== 1) begin
      errors++; $display("FAIL addi_retire got %0d want 1", ret_cnt - rb);
    end
    if (pc !== 32'h4) begin
      errors++; $display("FAIL addi_pc got %h want 4", pc);
    end
    wait_halt(200, tmo);
    checks++;
    if (tmo) begin
      errors++; $display("FAIL addi_halt got timeout want illegal");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (oi >= obs_addr.size()) begin
        errors++; $display("FAIL addi_store got none want %h", e);
      end else begin
        if ({obs_addr[oi], obs_data[oi]} !== e) begin
          errors++;
          $display("FAIL addi_store got %h %h want %h",
                   obs_addr[oi], obs_data[oi], e);
        end
        oi++;
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [63:0] e;
    int rb, oi, sb;
    bit tmo;
    hold_reset();
    dly = 3;
    prog[0] = ei(6'h08, 0, 1, 16'h0005);
    prog[1] = ei(6'h2B, 0, 1, 16'h0208);
    prog[2] = ei(6'h23, 0, 2, 16'h0208);
    prog[3] = ei(6'h2B, 0, 2, 16'h020C);
    exp_q.push_back({32'h208, 32'd5});
    exp_q.push_back({32'h20C, 32'd5});
    rb = ret_cyc.size();
    oi = obs_addr.size();
    sb = stab_err;
    rst = 1'b1;
    wait_halt(400, tmo);
    checks += 2;
    if (tmo) begin
      errors++; $display("FAIL wait_halt got timeout want illegal");
    end
    if (stab_err - sb !== 0) begin
      errors++; $display("FAIL wait_stable got %0d changes want 0", stab_err - sb);
    end
    checks++;
    if (ret_cyc.size() < rb + 4) begin
      errors++;
      $display("FAIL wait_retires got %0d want 4", ret_cyc.size() - rb);
    end else begin
      checks += 2;
      if (ret_cyc[rb+1] - ret_cyc[rb] !== 10) begin
        errors++;
        $display("FAIL sw_latency got %0d want 10", ret_cyc[rb+1] - ret_cyc[rb]);
      end
      if (ret_cyc[rb+2] - ret_cyc[rb+1] !== 11) begin
        errors++;
        $display("FAIL lw_latency got %0d want 11", ret_cyc[rb+2] - ret_cyc[rb+1]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (oi >= obs_addr.size()) begin
        errors++; $display("FAIL wait_store got none want %h", e);
      end else begin
        if ({obs_addr[oi], obs_data[oi]} !== e) begin
          errors++;
          $display("FAIL wait_store got %h %h want %h",
                   obs_addr[oi], obs_data[oi], e);
        end
        oi++;
      end
    end
  endtask

  task automatic test_alu();
    logic [63:0] e;
    int oi, ob;
    bit tmo;
    hold_reset();
    dly = 1;
    prog[8'hC0] = 32'h7FFF_FFFF;
    prog[0]  = ei(6'h23, 0, 1, 16'h0300);
    prog[1]  = ei(6'h08, 0, 2, 16'hFFFD);
    prog[2]  = ei(6'h08, 0, 8, 16'd100);
    prog[3]  = er(2, 2, 3, 6'h20);
    prog[4]  = er(8, 2, 4, 6'h22);
    prog[5]  = er(1, 2, 5, 6'h24);
    prog[6]  = er(8, 2, 6, 6'h25);
    prog[7]  = er(2, 8, 7, 6'h2A);
    prog[8]  = er(8, 2, 9, 6'h2A);
    prog[9]  = ei(6'h2B, 0, 3, 16'h0220);
    prog[10] = ei(6'h2B, 0, 4, 16'h0224);
    prog[11] = ei(6'h2B, 0, 5, 16'h0228);
    prog[12] = ei(6'h2B, 0, 6, 16'h022C);
    prog[13] = ei(6'h2B, 0, 7, 16'h0230);
    prog[14] = ei(6'h2B, 0, 9, 16'h0234);
    exp_q.push_back({32'h220, 32'hFFFF_FFFA});
    exp_q.push_back({32'h224, 32'h0000_0067});
    exp_q.push_back({32'h228, 32'h7FFF_FFFD});
    exp_q.push_back({32'h22C, 32'hFFFF_FFFD});
    exp_q.push_back({32'h230, 32'h0000_0001});
    exp_q.push_back({32'h234, 32'h0000_0000});
    oi = obs_addr.size();
    ob = ovf_cnt;
    rst = 1'b1;
    wait_halt(600, tmo);
    checks += 2;
    if (tmo) begin
      errors++; $display("FAIL alu_halt got timeout want illegal");
    end
    if (ovf_cnt - ob !== 0) begin
      errors++; $display("FAIL alu_ovf got %0d want 0", ovf_cnt - ob);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (oi >= obs_addr.size()) begin
        errors++; $display("FAIL alu_store got none want %h", e);
      end else begin
        if ({obs_addr[oi], obs_data[oi]} !== e) begin
          errors++;
          $display("FAIL alu_store got %h %h want %h",
                   obs_addr[oi], obs_data[oi], e);
        end
        oi++;
      end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] e;
    int oi, ob, rb, tb0;
    int want_ret;
    logic [31:0] want_pc;
    bit tmo;
    hold_reset();
    dly = 0;
    prog[8'hC0] = 32'h7FFF_FFFF;
    prog[0]    = ei(6'h23, 0, 1, 16'h0300);
    prog[1]    = ei(6'h08, 1, 2, 16'h0001);
    prog[2]    = ei(6'h2B, 0, 2, 16'h0240);
    prog[8'h20] = ei(6'h2B, 0, 2, 16'h0240);
`ifdef MC_OVF_TRAP_EN
    exp_q.push_back({32'h240, 32'h0000_0000});
    want_ret = 2;
    want_pc  = 32'h88;
`else
    exp_q.push_back({32'h240, 32'h8000_0000});
    want_ret = 3;
    want_pc  = 32'h10;
`endif
    oi  = obs_addr.size();
    ob  = ovf_cnt;
    rb  = ret_cnt;
    tb0 = trap_cnt;
    rst = 1'b1;
    wait_halt(200, tmo);
    checks += 4;
    if (tmo) begin
      errors++; $display("FAIL ovf_halt got timeout want illegal");
    end
    if (ovf_cnt - ob !== 1) begin
      errors++; $display("FAIL ovf_flag got %0d cycles want 1", ovf_cnt - ob);
    end
    if (ret_cnt - rb !== want_ret) begin
      errors++;
      $display("FAIL ovf_retire got %0d want %0d", ret_cnt - rb, want_ret);
    end
    if (pc !== want_pc) begin
      errors++; $display("FAIL ovf_pc got %h want %h", pc, want_pc);
    end
`ifdef MC_OVF_TRAP_EN
    checks++;
    if (trap_cnt - tb0 !== 1) begin
      errors++; $display("FAIL ovf_trap got %0d want 1", trap_cnt - tb0);
    end
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (oi >= obs_addr.size()) begin
        errors++; $display("FAIL ovf_store got none want %h", e);
      end else begin
        if ({obs_addr[oi], obs_data[oi]} !== e) begin
          errors++;
          $display("FAIL ovf_store got %h %h want %h",
                   obs_addr[oi], obs_data[oi], e);
        end
        oi++;
      end
    end
  endtask

  task automatic test_branch(input bit taken);
    int rb;
    bit tmo;
    logic [31:0] want_pc;
    hold_reset();
    dly = 0;
    prog[0] = ei(6'h08, 0, 1, 16'h0003);
    prog[1] = ei(6'h08, 0, 2, 16'h0004);
    prog[2] = ej(26'h4);
    prog[4] = ei(6'h04, 1, taken ? 5'd1 : 5'd2, 16'hFFFF);
    want_pc = taken ? 32'h10 : 32'h14;
    rb = ret_cnt;
    rst = 1'b1;
    wait_ret(rb, 3, 100, tmo);
    checks++;
    if (tmo) begin
      errors++; $display("FAIL beq_setup got timeout want 3 retires");
    end
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (pc !== want_pc) begin
      errors++; $display("FAIL beq_pc taken=%0b got %h want %h", taken, pc, want_pc);
    end
    if (ret_cnt - rb !== 4) begin
      errors++; $display("FAIL beq_retire got %0d want 4", ret_cnt - rb);
    end
  endtask

  task automatic test_jump();
    logic [63:0] e;
    int rb, oi;
    bit tmo;
    hold_reset();
    dly = 0;
    prog[0]     = ei(6'h08, 0, 1, 16'h0007);
    prog[1]     = ej(26'h8);
    prog[8]     = ej(26'h40);
    prog[8'h40] = er(1, 1, 0, 6'h20);
    prog[8'h41] = ei(6'h2B, 0, 0, 16'h0250);
    prog[8'h42] = ei(6'h2B, 0, 1, 16'h0254);
    exp_q.push_back({32'h250, 32'h0});
    exp_q.push_back({32'h254, 32'h7});
    rb = ret_cnt;
    oi = obs_addr.size();
    rst = 1'b1;
    wait_ret(rb, 2, 100, tmo);
    checks++;
    if (tmo) begin
      errors++; $display("FAIL j_setup got timeout want 2 retires");
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'h100) begin
      errors++; $display("FAIL j_pc got %h want 00000100", pc);
    end
    wait_halt(200, tmo);
    checks++;
    if (tmo) begin
      errors++; $display("FAIL j_halt got timeout want illegal");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (oi >= obs_addr.size()) begin
        errors++; $display("FAIL j_store got none want %h", e);
      end else begin
        if ({obs_addr[oi], obs_data[oi]} !== e) begin
          errors++;
          $display("FAIL j_store got %h %h want %h",
                   obs_addr[oi], obs_data[oi], e);
        end
        oi++;
      end
    end
  endtask

  task automatic test_illegal();
    int rb;
    bit req_seen;
    hold_reset();
    dly = 0;
    rb = ret_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      errors++; $display("FAIL ill_early got %b want 0", illegal);
    end
    @(posedge clk);
    #1;
    checks++;
    if (illegal !== 1'b1) begin
      errors++; $display("FAIL ill_set got %b want 1", illegal);
    end
    spur = 1'b1;
    req_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b0) req_seen = 1'b1;
    end
    spur = 1'b0;
    #1;
    checks += 4;
    if (req_seen) begin
      errors++; $display("FAIL ill_req got 1 want 0");
    end
    if (ret_cnt - rb !== 0) begin
      errors++; $display("FAIL ill_retire got %0d want 0", ret_cnt - rb);
    end
    if (pc !== 32'h4) begin
      errors++; $display("FAIL ill_pc got %h want 4", pc);
    end
    if (illegal !== 1'b1) begin
      errors++; $display("FAIL ill_sticky got %b want 1", illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks += 2;
    if (illegal !== 1'b0) begin
      errors++; $display("FAIL ill_clear got %b want 0", illegal);
    end
    if (pc !== 32'h0) begin
      errors++; $display("FAIL ill_rst_pc got %h want 0", pc);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_mem_wait();
    test_alu();
    test_overflow();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jump();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
